// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: 8259-style priority resolution, two-pulse INTA acknowledge, ISR and EOI/rotation control
module interrupt_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [4:0] vector_base,
  input  logic       aeoi_en,
  input  logic       rotate_aeoi,
  input  logic       inta,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] clear_irr,
  output logic [2:0] priority_rotate,
  output logic [7:0] data_out,
  output logic       data_en
);
  typedef enum logic {IDLE, ACK2} state_t;
  state_t state_q, state_d;
  logic [7:0] isr_q, isr_d, clear_irr_q, clear_irr_d, data_out_q, data_out_d;
  logic [7:0] req, ack_set, aeoi_clear, eoi_clear;
  logic [2:0] rot_q, rot_d, lvl_q, lvl_d, w_lvl, i_lvl, tgt;
  logic [3:0] w_rank, i_rank;
  logic       int_out_q, int_out_d, data_en_q, data_en_d, spur_q, spur_d;
  logic       eligible, eoi_hit, idle_ack, ack2_ack, aeoi_act;

  // rank 0 is the highest priority (rot+1); 8 means no bit set
  function automatic logic [3:0] top_rank(input logic [7:0] v, input logic [2:0] rot);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'd8;
    for (int k = 7; k >= 0; k--) begin
      idx = rot + 3'd1 + 3'(k);
      if (v[idx]) r = 4'(k);
    end
    return r;
  endfunction

  always_comb begin
    req         = irr & ~imr;
    w_rank      = top_rank(req, rot_q);
    i_rank      = top_rank(isr_q, rot_q);
    w_lvl       = rot_q + 3'd1 + w_rank[2:0];
    i_lvl       = rot_q + 3'd1 + i_rank[2:0];
    eligible    = w_rank < i_rank;
    tgt         = eoi_specific ? eoi_level : i_lvl;
    eoi_hit     = eoi_cmd && (eoi_specific || !i_rank[3]);
    eoi_clear   = eoi_hit ? 8'd1 << tgt : 8'd0;
    idle_ack    = state_q == IDLE && inta;
    ack2_ack    = state_q == ACK2 && inta;
    aeoi_act    = ack2_ack && aeoi_en && !spur_q;
    ack_set     = idle_ack && eligible ? 8'd1 << w_lvl : 8'd0;
    aeoi_clear  = aeoi_act ? 8'd1 << lvl_q : 8'd0;
    state_d     = inta ? (state_q == IDLE ? ACK2 : IDLE) : state_q;
    int_out_d   = state_q == IDLE && !inta && eligible;
    clear_irr_d = ack_set;
    lvl_d       = idle_ack ? (eligible ? w_lvl : 3'd7) : lvl_q;
    spur_d      = idle_ack ? !eligible : spur_q;
    data_en_d   = ack2_ack;
    data_out_d  = ack2_ack ? {vector_base, lvl_q} : data_out_q;
    // EOI rotation takes precedence over AEOI rotation in the same cycle
    rot_d       = eoi_hit && eoi_rotate ? tgt : (aeoi_act && rotate_aeoi ? lvl_q : rot_q);
    isr_d       = (isr_q & ~eoi_clear & ~aeoi_clear) | ack_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      isr_q       <= '0;
      clear_irr_q <= '0;
      data_out_q  <= '0;
      data_en_q   <= 1'b0;
      int_out_q   <= 1'b0;
      rot_q       <= 3'd7;
      lvl_q       <= '0;
      spur_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      isr_q       <= isr_d;
      clear_irr_q <= clear_irr_d;
      data_out_q  <= data_out_d;
      data_en_q   <= data_en_d;
      int_out_q   <= int_out_d;
      rot_q       <= rot_d;
      lvl_q       <= lvl_d;
      spur_q      <= spur_d;
    end
  end

  assign int_out         = int_out_q;
  assign isr             = isr_q;
  assign clear_irr       = clear_irr_q;
  assign priority_rotate = rot_q;
  assign data_out        = data_out_q;
  assign data_en         = data_en_q;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed scenarios plus randomized run against a priority-rule reference model
module tb_interrupt_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] irr = '0, imr = '0;
  logic [4:0] vector_base = '0;
  logic       aeoi_en = 1'b0, rotate_aeoi = 1'b0, inta = 1'b0;
  logic       eoi_cmd = 1'b0, eoi_specific = 1'b0, eoi_rotate = 1'b0;
  logic [2:0] eoi_level = '0;
  logic       int_out, data_en;
  logic [7:0] isr, clear_irr, data_out;
  logic [2:0] priority_rotate;
  int checks = 0, passes = 0;

  logic [7:0] m_isr = '0, m_clr = '0, m_dout = '0;
  logic [2:0] m_rot = 3'd7;
  logic       m_int = 1'b0, m_den = 1'b0, m_ack2 = 1'b0, m_spur = 1'b0;
  int         m_lvl = 0;

  interrupt_sequencer dut (
    .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .vector_base(vector_base),
    .aeoi_en(aeoi_en), .rotate_aeoi(rotate_aeoi), .inta(inta), .eoi_cmd(eoi_cmd),
    .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate), .eoi_level(eoi_level),
    .int_out(int_out), .isr(isr), .clear_irr(clear_irr), .priority_rotate(priority_rotate),
    .data_out(data_out), .data_en(data_en)
  );

  always #5 clk = ~clk;

  // smaller value = higher priority; rot+1 is priority 0
  function automatic int prio(int l, int rot);
    return (l - rot - 1 + 16) % 8;
  endfunction

  function automatic int top(logic [7:0] v, int rot);
    int b = -1;
    for (int l = 0; l < 8; l++)
      if (v[l] && (b < 0 || prio(l, rot) < prio(b, rot))) b = l;
    return b;
  endfunction

  task automatic tick;
    logic [7:0] n_isr, n_clr, n_dout, eclr, aclr, aset;
    logic [2:0] n_rot;
    logic       n_int, n_den, n_ack2, n_spur, elig;
    int         w, t, tg, n_lvl;
    w = top(irr & ~imr, int'(m_rot));
    t = top(m_isr, int'(m_rot));
    elig = w >= 0 && (t < 0 || prio(w, int'(m_rot)) < prio(t, int'(m_rot)));
    n_rot = m_rot; n_clr = '0; n_den = 1'b0; n_dout = m_dout; n_int = 1'b0;
    n_ack2 = m_ack2; n_spur = m_spur; n_lvl = m_lvl; eclr = '0; aclr = '0; aset = '0;
    if (!m_ack2) begin
      n_int = elig && !inta;
      if (inta) begin
        n_ack2 = 1'b1; n_spur = !elig; n_lvl = elig ? w : 7;
        if (elig) begin aset[w] = 1'b1; n_clr[w] = 1'b1; end
      end
    end else if (inta) begin
      n_ack2 = 1'b0; n_den = 1'b1; n_dout = {vector_base, 3'(m_lvl)};
      if (aeoi_en && !m_spur) begin
        aclr[m_lvl] = 1'b1;
        if (rotate_aeoi) n_rot = 3'(m_lvl);
      end
    end
    if (eoi_cmd) begin
      tg = eoi_specific ? int'(eoi_level) : t;
      if (tg >= 0) begin
        eclr[tg] = 1'b1;
        if (eoi_rotate) n_rot = 3'(tg);
      end
    end
    n_isr = (m_isr & ~eclr & ~aclr) | aset;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_isr = '0; m_clr = '0; m_dout = '0; m_rot = 3'd7; m_int = 0; m_den = 0; m_ack2 = 0; m_spur = 0; m_lvl = 0;
    end else begin
      m_isr = n_isr; m_clr = n_clr; m_dout = n_dout; m_rot = n_rot; m_int = n_int;
      m_den = n_den; m_ack2 = n_ack2; m_spur = n_spur; m_lvl = n_lvl;
    end
  endtask

  task automatic do_inta;
    inta = 1'b1; tick(); inta = 1'b0;
  endtask

  task automatic do_eoi(input logic spec, input logic rot, input logic [2:0] lvl);
    eoi_cmd = 1'b1; eoi_specific = spec; eoi_rotate = rot; eoi_level = lvl;
    tick();
    eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tick(); tick();
    checks++;
    if ({int_out, isr, clear_irr, priority_rotate, data_out, data_en} !== {1'b0, 8'h00, 8'h00, 3'd7, 8'h00, 1'b0})
      $display("FAIL reset: int=%b isr=%h clr=%h rot=%0d dout=%h den=%b, want 0 00 00 7 00 0",
               int_out, isr, clear_irr, priority_rotate, data_out, data_en);
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    vector_base = 5'b01000; irr = 8'b11010010; imr = '0;
    tick(); tick();
    checks++; if (int_out !== 1'b1) $display("FAIL basic_int: got %b want 1", int_out); else passes++;
    do_inta();
    checks++;
    if ({isr, clear_irr, int_out} !== {8'h02, 8'h02, 1'b0})
      $display("FAIL basic_ack1: isr=%h clr=%h int=%b want 02 02 0", isr, clear_irr, int_out);
    else passes++;
    irr = 8'b11010000;
    tick();
    checks++; if (clear_irr !== 8'h00) $display("FAIL basic_clr_pulse: got %h want 00", clear_irr); else passes++;
    do_inta();
    checks++;
    if ({data_out, data_en} !== {8'h41, 1'b1}) $display("FAIL basic_vec: dout=%h den=%b want 41 1", data_out, data_en);
    else passes++;
    tick();
    checks++;
    if ({data_out, data_en} !== {8'h41, 1'b0}) $display("FAIL basic_vec_hold: dout=%h den=%b want 41 0", data_out, data_en);
    else passes++;
  endtask

  task automatic test_nesting;
    irr = 8'h0D; imr = 8'h01;
    tick(); tick();
    checks++;
    if ({isr, int_out} !== {8'h02, 1'b0}) $display("FAIL nest_block: isr=%h int=%b want 02 0", isr, int_out);
    else passes++;
    do_eoi(1'b0, 1'b0, 3'd0);
    checks++; if (isr !== 8'h00) $display("FAIL nest_eoi: isr=%h want 00", isr); else passes++;
    tick();
    checks++; if (int_out !== 1'b1) $display("FAIL nest_int: got %b want 1", int_out); else passes++;
    do_inta();
    checks++;
    if ({isr, clear_irr} !== {8'h04, 8'h04}) $display("FAIL nest_win: isr=%h clr=%h want 04 04", isr, clear_irr);
    else passes++;
    irr = 8'h09;
    do_inta();
    checks++; if (data_out !== 8'h42) $display("FAIL nest_vec: got %h want 42", data_out); else passes++;
    do_eoi(1'b0, 1'b0, 3'd0);
    irr = '0; imr = '0;
  endtask

  task automatic test_spurious;
    irr = 8'h08; tick(); tick();
    irr = 8'h00;
    do_inta();
    checks++;
    if ({isr, clear_irr} !== {8'h00, 8'h00}) $display("FAIL spur_ack1: isr=%h clr=%h want 00 00", isr, clear_irr);
    else passes++;
    do_inta();
    checks++;
    if ({data_out, data_en} !== {vector_base, 3'd7, 1'b1})
      $display("FAIL spur_vec: dout=%h den=%b want %h 1", data_out, data_en, {vector_base, 3'd7});
    else passes++;
  endtask

  task automatic test_aeoi_rotate;
    aeoi_en = 1'b1; rotate_aeoi = 1'b1; irr = 8'h08;
    tick(); tick();
    do_inta();
    checks++; if (isr !== 8'h08) $display("FAIL aeoi_ack1: isr=%h want 08", isr); else passes++;
    irr = '0;
    do_inta();
    checks++;
    if ({isr, priority_rotate} !== {8'h00, 3'd3}) $display("FAIL aeoi_rot: isr=%h rot=%0d want 00 3", isr, priority_rotate);
    else passes++;
    irr = 8'h11; tick(); tick();
    do_inta();
    checks++;
    if ({isr, clear_irr} !== {8'h10, 8'h10}) $display("FAIL aeoi_next_win: isr=%h clr=%h want 10 10", isr, clear_irr);
    else passes++;
    irr = '0;
    do_inta();
    aeoi_en = 1'b0; rotate_aeoi = 1'b0;
  endtask

  task automatic test_specific_rotate;
    irr = 8'h04; tick(); tick(); do_inta(); irr = '0; do_inta();
    irr = 8'h20; tick(); tick(); do_inta(); irr = '0; do_inta();
    checks++; if (isr !== 8'h24) $display("FAIL spec_setup: isr=%h want 24", isr); else passes++;
    do_eoi(1'b1, 1'b1, 3'd5);
    checks++;
    if ({isr, priority_rotate} !== {8'h04, 3'd5}) $display("FAIL spec_rot: isr=%h rot=%0d want 04 5", isr, priority_rotate);
    else passes++;
    do_eoi(1'b0, 1'b0, 3'd0);
    do_eoi(1'b1, 1'b1, 3'd0);
    checks++;
    if ({isr, priority_rotate} !== {8'h00, 3'd0}) $display("FAIL spec_clear_bit_rot: isr=%h rot=%0d want 00 0", isr, priority_rotate);
    else passes++;
    do_eoi(1'b0, 1'b1, 3'd0);
    checks++; if (priority_rotate !== 3'd0) $display("FAIL nonspec_empty: rot=%0d want 0", priority_rotate); else passes++;
    do_eoi(1'b1, 1'b1, 3'd7);
  endtask

  task automatic test_reset_mid;
    irr = 8'h01; tick(); tick();
    do_inta();
    rst_n = 1'b0; tick();
    checks++;
    if ({int_out, isr, clear_irr, priority_rotate, data_en} !== {1'b0, 8'h00, 8'h00, 3'd7, 1'b0})
      $display("FAIL reset_mid: int=%b isr=%h clr=%h rot=%0d den=%b want 0 00 00 7 0",
               int_out, isr, clear_irr, priority_rotate, data_en);
    else passes++;
    rst_n = 1'b1; tick(); tick();
    do_inta();
    checks++;
    if ({isr, clear_irr, data_en} !== {8'h01, 8'h01, 1'b0})
      $display("FAIL reset_first_pulse: isr=%h clr=%h den=%b want 01 01 0", isr, clear_irr, data_en);
    else passes++;
    irr = '0;
    do_inta();
    checks++; if (data_en !== 1'b1) $display("FAIL reset_second_pulse: den=%b want 1", data_en); else passes++;
    do_eoi(1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_random;
    logic prev_inta = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = $urandom_range(0, 199) != 0;
      irr = 8'($urandom);
      imr = $urandom_range(0, 1) ? 8'($urandom) & 8'($urandom) : 8'h00;
      if ($urandom_range(0, 31) == 0) begin aeoi_en = 1'($urandom); rotate_aeoi = 1'($urandom); end
      if ($urandom_range(0, 15) == 0) vector_base = 5'($urandom);
      inta = !prev_inta && $urandom_range(0, 2) == 0;
      eoi_cmd = $urandom_range(0, 5) == 0;
      eoi_specific = 1'($urandom); eoi_rotate = 1'($urandom); eoi_level = 3'($urandom);
      prev_inta = inta;
      tick();
      checks++;
      if ({int_out, isr, clear_irr, priority_rotate, data_out, data_en} !== {m_int, m_isr, m_clr, m_rot, m_dout, m_den})
        $display("FAIL random cyc %0d: int=%b isr=%h clr=%h rot=%0d dout=%h den=%b want %b %h %h %0d %h %b", c,
                 int_out, isr, clear_irr, priority_rotate, data_out, data_en, m_int, m_isr, m_clr, m_rot, m_dout, m_den);
      else passes++;
    end
    inta = 1'b0; eoi_cmd = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nesting();
    test_spurious();
    test_aeoi_rotate();
    test_specific_rotate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
